id_ex_stage: RTL and testbench

//  ID/EX pipeline register of the 5-stage MIPS core, with built-in load-use hazard detection.

---
 rtl/id_ex_stage_pkg.sv | 27 ++
 rtl/id_ex_stage_if.sv | 73 +++++++
 rtl/id_ex_stage_load_use_detector.sv | 27 ++
 rtl/id_ex_stage.sv | 157 +++++++++++++++
 tb/tb_id_ex_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: default widths, ALU operation
// encodings and the hardwired zero register index.
package id_ex_stage_pkg;

  localparam int DEFAULT_LEN_DATA  = 32;
  localparam int DEFAULT_NB_REG    = 5;
  localparam int DEFAULT_NB_ALUOP  = 4;
  localparam int DEFAULT_NB_STALLC = 32;

  // Register $0 always reads zero; writes to it are discarded.
  localparam int REG_ZERO = 0;

  typedef enum logic [DEFAULT_NB_ALUOP-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between the decode side (master) and the ID/EX pipeline register
// (slave): decoded instruction fields in, registered EX fields and stall out.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int LEN_DATA  = DEFAULT_LEN_DATA,
  parameter int NB_REG    = DEFAULT_NB_REG,
  parameter int NB_ALUOP  = DEFAULT_NB_ALUOP,
  parameter int NB_STALLC = DEFAULT_NB_STALLC
);

  logic                enable;
  logic                flush;

  logic                id_valid;
  logic [NB_REG-1:0]   id_rs;
  logic [NB_REG-1:0]   id_rt;
  logic [NB_REG-1:0]   id_rd;
  logic [LEN_DATA-1:0] id_rs_data;
  logic [LEN_DATA-1:0] id_rt_data;
  logic [LEN_DATA-1:0] id_imm;
  logic [LEN_DATA-1:0] id_pc_plus4;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                id_mem_write;
  logic                id_mem_to_reg;
  logic                id_alu_src;
  logic                id_reg_dst;
  logic [NB_ALUOP-1:0] id_alu_op;

  logic                ex_valid;
  logic [NB_REG-1:0]   ex_rs;
  logic [NB_REG-1:0]   ex_rt;
  logic [NB_REG-1:0]   ex_rd;
  logic [LEN_DATA-1:0] ex_rs_data;
  logic [LEN_DATA-1:0] ex_rt_data;
  logic [LEN_DATA-1:0] ex_imm;
  logic [LEN_DATA-1:0] ex_pc_plus4;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic                ex_mem_to_reg;
  logic                ex_alu_src;
  logic                ex_reg_dst;
  logic [NB_ALUOP-1:0] ex_alu_op;
  logic [NB_REG-1:0]   ex_wr_reg;

  logic                 stall;
  logic [NB_STALLC-1:0] stall_count;

  modport master (
    output enable, flush, id_valid, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_pc_plus4,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_alu_src, id_reg_dst, id_alu_op,
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data,
           ex_imm, ex_pc_plus4, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_alu_op, ex_wr_reg,
           stall, stall_count
  );

  modport slave (
    input  enable, flush, id_valid, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_pc_plus4,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_alu_src, id_reg_dst, id_alu_op,
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data,
           ex_imm, ex_pc_plus4, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_alu_op, ex_wr_reg,
           stall, stall_count
  );

endinterface

// File: rtl/id_ex_stage_load_use_detector.sv
// Load-use hazard detector: a load sitting in EX whose destination is read
// by the instruction in ID cannot be forwarded in time, so ID must wait.
module load_use_detector
  import id_ex_stage_pkg::*;
#(
  parameter int NB_REG = DEFAULT_NB_REG
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [NB_REG-1:0] ex_wr_reg,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  input  logic              id_valid,
  input  logic              flush,
  output logic              stall
);

  logic hazard;

  // Hazard term, then gate it: a squashed or empty ID slot needs no stall.
  always_comb begin
    hazard = ex_valid & ex_mem_read & (ex_wr_reg != NB_REG'(REG_ZERO)) &
             ((ex_wr_reg == id_rs) | (ex_wr_reg == id_rt));
    stall  = hazard & id_valid & ~flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// count of inserted bubbles for the debug unit.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int LEN_DATA  = DEFAULT_LEN_DATA,
  parameter int NB_REG    = DEFAULT_NB_REG,
  parameter int NB_ALUOP  = DEFAULT_NB_ALUOP,
  parameter int NB_STALLC = DEFAULT_NB_STALLC
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  logic                stall;
  logic [NB_REG-1:0]   id_dest;

  logic                nxt_valid;
  logic [NB_REG-1:0]   nxt_rs, nxt_rt, nxt_rd, nxt_wr_reg;
  logic [LEN_DATA-1:0] nxt_rs_data, nxt_rt_data, nxt_imm, nxt_pc_plus4;
  logic                nxt_reg_write, nxt_mem_read, nxt_mem_write;
  logic                nxt_mem_to_reg, nxt_alu_src, nxt_reg_dst;
  logic [NB_ALUOP-1:0] nxt_alu_op;

  logic                ex_valid;
  logic [NB_REG-1:0]   ex_rs, ex_rt, ex_rd, ex_wr_reg;
  logic [LEN_DATA-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
  logic                ex_reg_write, ex_mem_read, ex_mem_write;
  logic                ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic [NB_ALUOP-1:0] ex_alu_op;

  logic [NB_STALLC-1:0] stall_count;

  load_use_detector #(.NB_REG(NB_REG)) u_load_use_detector (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_wr_reg   (ex_wr_reg),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_valid    (bus.id_valid),
    .flush       (bus.flush),
    .stall       (stall)
  );

  assign id_dest = bus.id_reg_dst ? bus.id_rd : bus.id_rt;

  // Next EX contents: a bubble (all zero) on flush or stall, otherwise the
  // ID fields, with control bits only for a real instruction and the
  // register write suppressed when the destination is $0.
  always_comb begin
    nxt_valid      = 1'b0;
    nxt_rs         = '0;
    nxt_rt         = '0;
    nxt_rd         = '0;
    nxt_wr_reg     = '0;
    nxt_rs_data    = '0;
    nxt_rt_data    = '0;
    nxt_imm        = '0;
    nxt_pc_plus4   = '0;
    nxt_reg_write  = 1'b0;
    nxt_mem_read   = 1'b0;
    nxt_mem_write  = 1'b0;
    nxt_mem_to_reg = 1'b0;
    nxt_alu_src    = 1'b0;
    nxt_reg_dst    = 1'b0;
    nxt_alu_op     = '0;
    if (!bus.flush && !stall) begin
      nxt_rs       = bus.id_rs;
      nxt_rt       = bus.id_rt;
      nxt_rd       = bus.id_rd;
      nxt_wr_reg   = id_dest;
      nxt_rs_data  = bus.id_rs_data;
      nxt_rt_data  = bus.id_rt_data;
      nxt_imm      = bus.id_imm;
      nxt_pc_plus4 = bus.id_pc_plus4;
      if (bus.id_valid) begin
        nxt_valid      = 1'b1;
        nxt_reg_write  = bus.id_reg_write & (id_dest != NB_REG'(REG_ZERO));
        nxt_mem_read   = bus.id_mem_read;
        nxt_mem_write  = bus.id_mem_write;
        nxt_mem_to_reg = bus.id_mem_to_reg;
        nxt_alu_src    = bus.id_alu_src;
        nxt_reg_dst    = bus.id_reg_dst;
        nxt_alu_op     = bus.id_alu_op;
      end
    end
  end

  // Pipeline register: advances only while the debug unit enables stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_wr_reg     <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_pc_plus4   <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_op     <= '0;
    end else if (bus.enable) begin
      ex_valid      <= nxt_valid;
      ex_rs         <= nxt_rs;
      ex_rt         <= nxt_rt;
      ex_rd         <= nxt_rd;
      ex_wr_reg     <= nxt_wr_reg;
      ex_rs_data    <= nxt_rs_data;
      ex_rt_data    <= nxt_rt_data;
      ex_imm        <= nxt_imm;
      ex_pc_plus4   <= nxt_pc_plus4;
      ex_reg_write  <= nxt_reg_write;
      ex_mem_read   <= nxt_mem_read;
      ex_mem_write  <= nxt_mem_write;
      ex_mem_to_reg <= nxt_mem_to_reg;
      ex_alu_src    <= nxt_alu_src;
      ex_reg_dst    <= nxt_reg_dst;
      ex_alu_op     <= nxt_alu_op;
    end
  end

  // Count load-use bubbles actually inserted, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (bus.enable && stall && (stall_count != '1)) begin
      stall_count <= stall_count + NB_STALLC'(1);
    end
  end

  assign bus.ex_valid      = ex_valid;
  assign bus.ex_rs         = ex_rs;
  assign bus.ex_rt         = ex_rt;
  assign bus.ex_rd         = ex_rd;
  assign bus.ex_wr_reg     = ex_wr_reg;
  assign bus.ex_rs_data    = ex_rs_data;
  assign bus.ex_rt_data    = ex_rt_data;
  assign bus.ex_imm        = ex_imm;
  assign bus.ex_pc_plus4   = ex_pc_plus4;
  assign bus.ex_reg_write  = ex_reg_write;
  assign bus.ex_mem_read   = ex_mem_read;
  assign bus.ex_mem_write  = ex_mem_write;
  assign bus.ex_mem_to_reg = ex_mem_to_reg;
  assign bus.ex_alu_src    = ex_alu_src;
  assign bus.ex_reg_dst    = ex_reg_dst;
  assign bus.ex_alu_op     = ex_alu_op;
  assign bus.stall         = stall;
  assign bus.stall_count   = stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed hazard/flush/hold/saturation sequences
// followed by random traffic, all checked through a scoreboard fed by a
// behavioural model of what the EX stage should hold after each edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int LD = 32;
  localparam int NR = 5;
  localparam int NA = 4;
  localparam int NS = 4;
  localparam int COUNT_MAX = (1 << NS) - 1;

  typedef struct packed {
    logic          valid;
    logic [NR-1:0] rs, rt, rd, wr_reg;
    logic [LD-1:0] rs_data, rt_data, imm, pc4;
    logic          reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
    logic [NA-1:0] alu_op;
  } ex_t;

  typedef struct packed {
    logic          enable, flush, valid;
    logic [NR-1:0] rs, rt, rd;
    logic [LD-1:0] rs_data, rt_data, imm, pc4;
    logic          reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
    logic [NA-1:0] alu_op;
  } stim_t;

  typedef struct packed {
    logic          stall;
    ex_t           ex;
    logic [NS-1:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.LEN_DATA(LD), .NB_REG(NR), .NB_ALUOP(NA), .NB_STALLC(NS)) bus ();

  id_ex_stage #(.LEN_DATA(LD), .NB_REG(NR), .NB_ALUOP(NA), .NB_STALLC(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  ex_t  m_ex;
  int   m_count;

  function automatic ex_t read_dut();
    ex_t a;
    a.valid      = bus.ex_valid;
    a.rs         = bus.ex_rs;
    a.rt         = bus.ex_rt;
    a.rd         = bus.ex_rd;
    a.wr_reg     = bus.ex_wr_reg;
    a.rs_data    = bus.ex_rs_data;
    a.rt_data    = bus.ex_rt_data;
    a.imm        = bus.ex_imm;
    a.pc4        = bus.ex_pc_plus4;
    a.reg_write  = bus.ex_reg_write;
    a.mem_read   = bus.ex_mem_read;
    a.mem_write  = bus.ex_mem_write;
    a.mem_to_reg = bus.ex_mem_to_reg;
    a.alu_src    = bus.ex_alu_src;
    a.reg_dst    = bus.ex_reg_dst;
    a.alu_op     = bus.ex_alu_op;
    return a;
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a load in EX blocks an ID reader of its destination
  // for one cycle; otherwise EX simply takes what ID decoded.
  task automatic applyStimulus(input stim_t s);
    exp_t       e;
    bit         load_use;
    logic [NR-1:0] dest;
    @(negedge clk);
    bus.enable        = s.enable;
    bus.flush         = s.flush;
    bus.id_valid      = s.valid;
    bus.id_rs         = s.rs;
    bus.id_rt         = s.rt;
    bus.id_rd         = s.rd;
    bus.id_rs_data    = s.rs_data;
    bus.id_rt_data    = s.rt_data;
    bus.id_imm        = s.imm;
    bus.id_pc_plus4   = s.pc4;
    bus.id_reg_write  = s.reg_write;
    bus.id_mem_read   = s.mem_read;
    bus.id_mem_write  = s.mem_write;
    bus.id_mem_to_reg = s.mem_to_reg;
    bus.id_alu_src    = s.alu_src;
    bus.id_reg_dst    = s.reg_dst;
    bus.id_alu_op     = s.alu_op;

    load_use = m_ex.valid && m_ex.mem_read && (m_ex.wr_reg != 0) &&
               (m_ex.wr_reg == s.rs || m_ex.wr_reg == s.rt);
    e.stall = load_use && s.valid && !s.flush;
    if (s.enable) begin
      if (s.flush || e.stall) begin
        m_ex = '0;
        if (e.stall && m_count < COUNT_MAX) m_count++;
      end else begin
        dest = s.reg_dst ? s.rd : s.rt;
        m_ex = '0;
        m_ex.rs = s.rs; m_ex.rt = s.rt; m_ex.rd = s.rd; m_ex.wr_reg = dest;
        m_ex.rs_data = s.rs_data; m_ex.rt_data = s.rt_data;
        m_ex.imm = s.imm; m_ex.pc4 = s.pc4;
        if (s.valid) begin
          m_ex.valid      = 1'b1;
          m_ex.reg_write  = s.reg_write && (dest != 0);
          m_ex.mem_read   = s.mem_read;
          m_ex.mem_write  = s.mem_write;
          m_ex.mem_to_reg = s.mem_to_reg;
          m_ex.alu_src    = s.alu_src;
          m_ex.reg_dst    = s.reg_dst;
          m_ex.alu_op     = s.alu_op;
        end
      end
    end
    e.ex    = m_ex;
    e.count = NS'(m_count);
    exp_q.push_back(e);
  endtask

  // Asynchronous reset asserted in the middle of a cycle must clear at once.
  task automatic applyReset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_ex_async", read_dut(), '0);
    checkOutput("reset_count_async", bus.stall_count, '0);
    m_ex = '0;
    m_count = 0;
    @(posedge clk);
    #1;
    checkOutput("reset_ex_held", read_dut(), '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic stim_t instr(input int rs, input int rt, input int rd,
                                  input bit reg_dst, input bit reg_write, input bit mem_read);
    stim_t s;
    s = '0;
    s.enable = 1'b1;
    s.valid = 1'b1;
    s.rs = NR'(rs); s.rt = NR'(rt); s.rd = NR'(rd);
    s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom; s.pc4 = $urandom;
    s.reg_dst = reg_dst;
    s.reg_write = reg_write;
    s.mem_read = mem_read;
    s.mem_to_reg = mem_read;
    s.alu_src = mem_read;
    s.alu_op = mem_read ? NA'(ALU_ADD) : NA'($urandom_range(0, 15));
    return s;
  endfunction

  function automatic stim_t random_stim();
    stim_t s;
    s = instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    if ($urandom_range(0, 2) == 0) s.rs = m_ex.wr_reg;
    if ($urandom_range(0, 3) == 0) s.rt = m_ex.wr_reg;
    s.enable     = ($urandom_range(0, 7) != 0);
    s.flush      = ($urandom_range(0, 7) == 0);
    s.valid      = ($urandom_range(0, 7) != 0);
    s.mem_write  = 1'($urandom_range(0, 1));
    s.mem_to_reg = 1'($urandom_range(0, 1));
    s.alu_src    = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Monitor: the stall output is checked before the edge, the registered
  // fields and counter just after it.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("stall", bus.stall, e.stall);
        @(posedge clk);
        #1;
        checkOutput("ex_fields", read_dut(), e.ex);
        checkOutput("stall_count", bus.stall_count, e.count);
      end
    end
  end

  initial begin : driver
    stim_t s;
    m_ex = '0;
    m_count = 0;
    bus.enable = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0; bus.id_pc_plus4 = '0;
    bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
    bus.id_mem_to_reg = 1'b0; bus.id_alu_src = 1'b0; bus.id_reg_dst = 1'b0;
    bus.id_alu_op = '0;
    applyReset();

    // Reset with a register-writing instruction already in EX.
    applyStimulus(instr(1, 2, 9, 1, 1, 0));
    applyReset();

    // Normal R-type: destination taken from rd.
    applyStimulus(instr(3, 4, 5, 1, 1, 0));

    // lw $8 followed by a reader of $8: one bubble, then the reader loads.
    applyStimulus(instr(2, 8, 0, 0, 1, 1));
    s = instr(8, 9, 10, 1, 1, 0);
    applyStimulus(s);
    applyStimulus(s);

    // Loads into $0 never stall, and writes to $0 are dropped.
    applyStimulus(instr(2, 0, 0, 0, 1, 1));
    applyStimulus(instr(0, 0, 0, 1, 1, 0));
    applyStimulus(instr(6, 7, 0, 1, 1, 0));

    // Flush on top of a load-use pair: bubble, no stall, count untouched.
    applyStimulus(instr(2, 8, 0, 0, 1, 1));
    s = instr(8, 3, 11, 1, 1, 0);
    s.flush = 1'b1;
    applyStimulus(s);

    // Debug hold with a load in EX and a dependent reader waiting in ID.
    applyStimulus(instr(2, 8, 0, 0, 1, 1));
    for (int i = 0; i < 3; i++) begin
      s = random_stim();
      s.enable = 1'b0;
      s.rs = 5'd8;
      s.valid = 1'b1;
      s.flush = 1'b0;
      applyStimulus(s);
    end
    applyStimulus(instr(8, 1, 12, 1, 1, 0));

    // Drive the counter into saturation and one step beyond.
    for (int i = 0; i < COUNT_MAX + 2; i++) begin
      applyStimulus(instr(2, 8, 0, 0, 1, 1));
      applyStimulus(instr(1, 8, 13, 1, 1, 0));
    end

    for (int i = 0; i < 800; i++) applyStimulus(random_stim());
    applyReset();
    for (int i = 0; i < 800; i++) applyStimulus(random_stim());

    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
